io_in_deser_cell: RTL and testbench
===================================

# io_in_deser_cell

Serial-to-parallel deserializer on the fabric side of the IO input register cell. It consumes the registered or bypassed pad bit (IQZ) one bit per enabled clock and assembles WIDTH-bit words. Completed words are presented to fabric logic through a single-entry valid/ready holding register. A sticky overflow flag records any word lost to backpressure.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, bit ordering: 1 = first received bit lands in DOUT[WIDTH-1]; 0 = first received bit lands in DOUT[0].
- IQC  input  1  clock; all state updates on its rising edge.
- QRTN  input  1  reset, synchronous, active-low.
- IQZ_$inp  input  1  serial data bit from the IO input register cell.
- SEN_$inp  input  1  shift enable; IQZ_$inp is sampled only when high.
- SYNC_$inp  input  1  word-alignment strobe; discards any partial word.
- DRDY_$inp  input  1  consumer ready.
- OVFCLR_$inp  input  1  clears the sticky overflow flag.
- DOUT_$out  output  WIDTH  completed word, held stable while DVLD_$out=1.
- DVLD_$out  output  1  holding register contains an unconsumed word.
- OVF_$out  output  1  sticky overflow flag.
- BCNT_$out  output  clog2(WIDTH)  bits collected in the current partial word (debug/verification).

## Operation
- State:
  - Shift register SR[WIDTH-1:0].
  - Bit counter BCNT, range 0..WIDTH-1.
  - Holding register HOLD with valid bit V.
  - Overflow flag OVF.
- Shift when SEN=1:
  - MSB_FIRST=1: SR <= {SR[WIDTH-2:0], IQZ}.
  - MSB_FIRST=0: SR <= {IQZ, SR[WIDTH-1:1]}.
- Counter:
  - SEN=1 and BCNT<WIDTH-1: BCNT increments.
  - SEN=1 and BCNT=WIDTH-1: the word completes and BCNT wraps to 0.
- Word completion: the assembled word is {SR shifted with the current IQZ}, i.e. it includes the bit sampled on that edge.
  - If V=0, or V=1 with DRDY=1 on the same edge: HOLD <= word, V <= 1.
  - Otherwise (V=1, DRDY=0): the word is dropped, HOLD is unchanged, and OVF <= 1.
- Consume: V=1 and DRDY=1 with no completion on that edge gives V <= 0. HOLD keeps its value, and DOUT is don't-care once DVLD=0.
- Alignment:
  - SYNC=1, SEN=0: BCNT <= 0 and SR is unchanged (its contents are treated as stale).
  - SYNC=1, SEN=1: the partial word is discarded and the bit sampled on that edge becomes bit 1 of the new word, so BCNT <= 1.
  - SYNC never aborts or alters a word already in HOLD.
  - When WIDTH bits are collected after SYNC, the stale SR contents have been fully shifted out, so no masking is required.
- Overflow flag:
  - Overflow on an edge sets OVF to 1.
  - OVFCLR=1 with no overflow on that edge sets OVF to 0.
  - Set takes priority over clear when both occur on the same edge.
- Reset (QRTN=0 at an edge) takes priority over everything. After that edge:
  - SR=0, BCNT=0, HOLD=0, V=0, OVF=0.
  - All outputs are 0.
- DVLD_$out=V, DOUT_$out=HOLD, OVF_$out=OVF, BCNT_$out=BCNT.

## Timing
- Outputs are fully registered; there is no combinational path from any input to any output.
- Latency: when the last bit of a word is sampled on edge k, DVLD and DOUT are valid from just after edge k. Minimum word period is WIDTH cycles (SEN held high).
- Handshake:
  - A transfer occurs on each edge where DVLD=1 and DRDY=1.
  - DOUT and DVLD do not change while DVLD=1 and DRDY=0, except via reset.
  - DRDY may be asserted at any time without waiting for DVLD.
- Back-to-back words at full rate with DRDY tied high:
  - DVLD stays 1 continuously after the first word.
  - Each new word replaces the previous one on its completion edge.
- Reset released mid-stream: the first word completes exactly WIDTH enabled samples after the first edge with QRTN=1.
- SEN gaps (SEN=0 cycles) only stretch the word and never corrupt it.

## Test plan
- Reset: hold QRTN=0 for 3 cycles with random inputs, then release -> DOUT=0, DVLD=0, OVF=0, BCNT=0 for all 3 cycles and the first cycle after release.
- WIDTH=8, MSB_FIRST=1, SEN=1, DRDY=1, serial bits 1,0,1,1,0,0,1,0 -> DOUT=0xB2 with DVLD=1 immediately after the 8th edge. With MSB_FIRST=0 the same bits give DOUT=0x4D.
- Backpressure:
  - DRDY=0, stream two words 0xA5 then 0x3C -> DOUT stays 0xA5, OVF=1 after the 16th edge.
  - Then pulse DRDY for one cycle -> DVLD=0.
  - Then pulse OVFCLR -> OVF=0.
- Simultaneous drain and completion: V=1 holding 0x11, word 0x22 completes on the same edge DRDY=1 -> DOUT=0x22, DVLD stays 1, OVF stays 0.
- Alignment:
  - Send 3 bits, then SYNC=1 with SEN=1 and bit 1, then 7 more bits 0,1,0,1,0,1,0 -> DOUT=0xAA (MSB_FIRST=1), BCNT=1 right after the SYNC edge.
  - SYNC with SEN=0 gives BCNT=0.
- Overflow set/clear collision: OVFCLR=1 on the same edge a word is dropped -> OVF=1. Reset asserted mid-word (BCNT=5) -> BCNT=0, no word emitted.

Source files
------------

// File: rtl/io_in_deser_cell.sv
// Serial-to-parallel deserializer for the IO input register cell.
// Assembles WIDTH-bit words from IQZ and offers them through a one-entry valid/ready register.
module io_in_deser_cell #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             IQC,
   input  logic             QRTN,
   input  logic             IQZ_i,
   input  logic             SEN_i,
   input  logic             SYNC_i,
   input  logic             DRDY_i,
   input  logic             OVFCLR_i,
   output logic [WIDTH-1:0] DOUT_o,
   output logic             DVLD_o,
   output logic             OVF_o,
   output logic [BW-1:0]    BCNT_o
);

   localparam logic [BW-1:0] BCNT_LAST = BW'(WIDTH - 1);

   logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [BW-1:0]    bcnt_q, bcnt_d;
   logic             v_q, v_d;
   logic             ovf_q, ovf_d;
   logic             complete, accept, drop;

   always_comb begin
      sr_shift = sr_q;
      if (MSB_FIRST) sr_shift = {sr_q[WIDTH-2:0], IQZ_i};
      else           sr_shift = {IQZ_i, sr_q[WIDTH-1:1]};
   end

   // A SYNC edge starts a new word, so it can never complete the old one.
   assign complete = SEN_i && !SYNC_i && (bcnt_q == BCNT_LAST);
   assign accept   = complete && (!v_q || DRDY_i);
   assign drop     = complete && v_q && !DRDY_i;

   always_comb begin
      sr_d   = SEN_i ? sr_shift : sr_q;
      hold_d = accept ? sr_shift : hold_q;

      bcnt_d = bcnt_q;
      if (SYNC_i)      bcnt_d = SEN_i ? BW'(1) : '0;
      else if (SEN_i)  bcnt_d = (bcnt_q == BCNT_LAST) ? '0 : bcnt_q + BW'(1);

      v_d = v_q;
      if (accept)               v_d = 1'b1;
      else if (v_q && DRDY_i)   v_d = 1'b0;

      // Losing a word must stay visible even if software clears on the same edge.
      ovf_d = ovf_q;
      if (drop)          ovf_d = 1'b1;
      else if (OVFCLR_i) ovf_d = 1'b0;
   end

   always_ff @(posedge IQC) begin
      if (!QRTN) begin
         sr_q   <= '0;
         hold_q <= '0;
         bcnt_q <= '0;
         v_q    <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         sr_q   <= sr_d;
         hold_q <= hold_d;
         bcnt_q <= bcnt_d;
         v_q    <= v_d;
         ovf_q  <= ovf_d;
      end
   end

   assign DOUT_o = hold_q;
   assign DVLD_o = v_q;
   assign OVF_o  = ovf_q;
   assign BCNT_o = bcnt_q;

endmodule

// File: tb/tb_io_in_deser_cell.sv
// Scoreboard bench for io_in_deser_cell: an MSB-first and an LSB-first instance share stimulus,
// a monitor pops expected words on every transfer, the main process checks flags and counters.
module tb_io_in_deser_cell;

   logic       IQC = 1'b0;
   logic       QRTN, IQZ, SEN, SYNC, DRDY, OVFCLR;
   logic [7:0] dout_m, dout_l;
   logic       dvld_m, dvld_l, ovf_m, ovf_l;
   logic [2:0] bcnt_m, bcnt_l;

   int total = 0;
   int bad   = 0;
   logic [7:0] q_m[$];
   logic [7:0] q_l[$];

   always #5 IQC = ~IQC;

   io_in_deser_cell #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .IQC(IQC), .QRTN(QRTN), .IQZ_i(IQZ), .SEN_i(SEN), .SYNC_i(SYNC), .DRDY_i(DRDY),
      .OVFCLR_i(OVFCLR), .DOUT_o(dout_m), .DVLD_o(dvld_m), .OVF_o(ovf_m), .BCNT_o(bcnt_m));

   io_in_deser_cell #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .IQC(IQC), .QRTN(QRTN), .IQZ_i(IQZ), .SEN_i(SEN), .SYNC_i(SYNC), .DRDY_i(DRDY),
      .OVFCLR_i(OVFCLR), .DOUT_o(dout_l), .DVLD_o(dvld_l), .OVF_o(ovf_l), .BCNT_o(bcnt_l));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge IQC);
      #1;
   endtask

   task automatic send_bit(input logic b);
      IQZ = b;
      SEN = 1'b1;
      step();
      SEN = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic expect_word(input logic [7:0] wm, input logic [7:0] wl);
      q_m.push_back(wm);
      q_l.push_back(wl);
   endtask

   // Transfers happen at the next rising edge when DVLD and DRDY are both high.
   always @(negedge IQC) begin
      if (QRTN === 1'b1 && dvld_m === 1'b1 && DRDY === 1'b1) begin
         if (q_m.size() == 0) chk("unexpected_word_m", {24'd0, dout_m}, 32'hFFFF_FFFF);
         else chk("word_m", {24'd0, dout_m}, {24'd0, q_m.pop_front()});
      end
      if (QRTN === 1'b1 && dvld_l === 1'b1 && DRDY === 1'b1) begin
         if (q_l.size() == 0) chk("unexpected_word_l", {24'd0, dout_l}, 32'hFFFF_FFFF);
         else chk("word_l", {24'd0, dout_l}, {24'd0, q_l.pop_front()});
      end
   end

   initial begin
      logic [7:0] w;
      // Reset with random inputs for 3 cycles, then one idle cycle after release.
      QRTN = 1'b0;
      for (int c = 0; c < 3; c++) begin
         IQZ = 1'($urandom); SEN = 1'($urandom); SYNC = 1'($urandom);
         DRDY = 1'($urandom); OVFCLR = 1'($urandom);
         step();
         chk("rst_dout", {24'd0, dout_m}, 32'd0);
         chk("rst_dvld", {31'd0, dvld_m}, 32'd0);
         chk("rst_ovf", {31'd0, ovf_m}, 32'd0);
         chk("rst_bcnt", {29'd0, bcnt_m}, 32'd0);
      end
      QRTN = 1'b1; IQZ = 1'b0; SEN = 1'b0; SYNC = 1'b0; DRDY = 1'b0; OVFCLR = 1'b0;
      step();
      chk("post_rst_dout", {24'd0, dout_m}, 32'd0);
      chk("post_rst_dvld", {31'd0, dvld_m}, 32'd0);
      chk("post_rst_ovf", {31'd0, ovf_m}, 32'd0);
      chk("post_rst_bcnt", {29'd0, bcnt_m}, 32'd0);

      // Basic word: bits 1,0,1,1,0,0,1,0.
      DRDY = 1'b1;
      expect_word(8'hB2, 8'h4D);
      send_word(8'hB2);
      chk("basic_dvld", {31'd0, dvld_m}, 32'd1);
      chk("basic_dout_m", {24'd0, dout_m}, 32'hB2);
      chk("basic_dout_l", {24'd0, dout_l}, 32'h4D);
      chk("basic_bcnt", {29'd0, bcnt_m}, 32'd0);
      step();
      chk("basic_drained", {31'd0, dvld_m}, 32'd0);

      // Backpressure: second word dropped, first held.
      DRDY = 1'b0;
      expect_word(8'hA5, 8'hA5);
      send_word(8'hA5);
      send_word(8'h3C);
      chk("bp_dout", {24'd0, dout_m}, 32'hA5);
      chk("bp_dvld", {31'd0, dvld_m}, 32'd1);
      chk("bp_ovf", {31'd0, ovf_m}, 32'd1);
      chk("bp_ovf_l", {31'd0, ovf_l}, 32'd1);
      DRDY = 1'b1;
      step();
      DRDY = 1'b0;
      chk("bp_drain_dvld", {31'd0, dvld_m}, 32'd0);
      chk("bp_ovf_sticky", {31'd0, ovf_m}, 32'd1);
      OVFCLR = 1'b1;
      step();
      OVFCLR = 1'b0;
      chk("ovf_clear", {31'd0, ovf_m}, 32'd0);

      // Drain and completion on the same edge.
      expect_word(8'h11, 8'h88);
      send_word(8'h11);
      chk("sim_hold_dvld", {31'd0, dvld_m}, 32'd1);
      expect_word(8'h22, 8'h44);
      w = 8'h22;
      for (int i = 7; i >= 1; i--) send_bit(w[i]);
      DRDY = 1'b1;
      send_bit(w[0]);
      chk("sim_dout", {24'd0, dout_m}, 32'h22);
      chk("sim_dvld", {31'd0, dvld_m}, 32'd1);
      chk("sim_ovf", {31'd0, ovf_m}, 32'd0);
      step();
      chk("sim_drained", {31'd0, dvld_m}, 32'd0);

      // Alignment with SEN=1: the sync bit becomes bit 1 of the new word.
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      chk("pre_sync_bcnt", {29'd0, bcnt_m}, 32'd3);
      SYNC = 1'b1;
      send_bit(1'b1);
      SYNC = 1'b0;
      chk("sync_bcnt", {29'd0, bcnt_m}, 32'd1);
      expect_word(8'hAA, 8'h55);
      w = 8'hAA;
      for (int i = 6; i >= 0; i--) send_bit(w[i]);
      chk("sync_dout", {24'd0, dout_m}, 32'hAA);
      chk("sync_dvld", {31'd0, dvld_m}, 32'd1);
      step();
      // Alignment with SEN=0.
      send_bit(1'b0); send_bit(1'b1);
      SYNC = 1'b1;
      step();
      SYNC = 1'b0;
      chk("sync_idle_bcnt", {29'd0, bcnt_m}, 32'd0);

      // Overflow set beats clear on the same edge.
      DRDY = 1'b0;
      expect_word(8'h0F, 8'hF0);
      send_word(8'h0F);
      w = 8'h33;
      for (int i = 7; i >= 1; i--) send_bit(w[i]);
      OVFCLR = 1'b1;
      send_bit(w[0]);
      OVFCLR = 1'b0;
      chk("collide_ovf", {31'd0, ovf_m}, 32'd1);
      chk("collide_dout", {24'd0, dout_m}, 32'h0F);
      DRDY = 1'b1;
      step();
      chk("collide_drained", {31'd0, dvld_m}, 32'd0);
      OVFCLR = 1'b1;
      step();
      OVFCLR = 1'b0;
      chk("collide_clear", {31'd0, ovf_m}, 32'd0);

      // Reset mid-word, then the first word completes after exactly 8 samples.
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      chk("mid_bcnt", {29'd0, bcnt_m}, 32'd5);
      QRTN = 1'b0; SEN = 1'b1; IQZ = 1'b1;
      step();
      SEN = 1'b0; QRTN = 1'b1;
      chk("mid_rst_bcnt", {29'd0, bcnt_m}, 32'd0);
      chk("mid_rst_dvld", {31'd0, dvld_m}, 32'd0);
      expect_word(8'hC3, 8'hC3);
      w = 8'hC3;
      for (int i = 7; i >= 1; i--) send_bit(w[i]);
      chk("restart_not_yet", {31'd0, dvld_m}, 32'd0);
      send_bit(w[0]);
      chk("restart_dvld", {31'd0, dvld_m}, 32'd1);
      chk("restart_dout", {24'd0, dout_m}, 32'hC3);

      // SEN gaps stretch a word without corrupting it.
      expect_word(8'h96, 8'h69);
      w = 8'h96;
      for (int i = 7; i >= 0; i--) begin
         send_bit(w[i]);
         IQZ = ~w[i];
         step();
      end
      chk("gap_dout", {24'd0, dout_m}, 32'h96);
      chk("gap_dout_l", {24'd0, dout_l}, 32'h69);
      step();
      step();
      chk("queue_m_empty", q_m.size(), 32'd0);
      chk("queue_l_empty", q_l.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
